// File: rtl/instr_fetch_axi_master.sv
// AXI-style single-burst instruction fetch initiator with a small instruction FIFO.
// Optional beat/response checking is compiled in with `define FETCH_ERR_CHECK_EN.
module instr_fetch_axi_master #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_addr,
  output logic             req_ready,
  input  logic             flush,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_addr,
  input  logic             instr_ready,
  output logic             arvalid,
  output logic [WIDTH-1:0] araddr,
  output logic [1:0]       arburst,
  output logic [2:0]       arsize,
  output logic [7:0]       arlen,
  input  logic             arready,
  input  logic             rvalid,
  input  logic [WIDTH-1:0] rdata,
  input  logic             rlast,
  input  logic             rresp,
  output logic             rready,
  output logic             busy,
  output logic             err
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t           r_state, w_state_next;
  logic             r_flush_pend, w_flush_pend_next;
  logic             r_arvalid, r_busy;
  logic [WIDTH-1:0] r_araddr, r_beat_addr;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW:0]      r_count;
  logic [WIDTH-1:0] r_mem_data [BUF_DEPTH];
  logic [WIDTH-1:0] r_mem_addr [BUF_DEPTH];

  logic w_full, w_rready, w_req_ready, w_beat_acc, w_push, w_pop, w_req_hs, w_ar_hs;

  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = (r_count != '0) && instr_ready;
  assign w_beat_acc = rvalid && w_rready;
  // A beat accepted in the flush cycle is consumed from the bus but never stored.
  assign w_push     = w_beat_acc && (r_state == S_DATA) && !flush;
  assign w_req_hs   = req_valid && w_req_ready;
  assign w_ar_hs    = (r_state == S_ADDR) && arready;

  always_comb begin
    w_state_next      = r_state;
    w_flush_pend_next = r_flush_pend;
    w_rready          = 1'b0;
    w_req_ready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !flush;
        if (req_valid && !flush) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (flush) w_flush_pend_next = 1'b1;
        if (arready) begin
          w_state_next      = (r_flush_pend || flush) ? S_DRAIN : S_DATA;
          w_flush_pend_next = 1'b0;
        end
      end
      S_DATA: begin
        w_rready = !w_full;
        if (rvalid && !w_full && rlast) w_state_next = S_IDLE;
        else if (flush)                 w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_rready = 1'b1;
        if (rvalid && rlast) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_flush_pend <= 1'b0;
      r_arvalid    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_pend <= w_flush_pend_next;
      r_arvalid    <= (w_state_next == S_ADDR);
      r_busy       <= (w_state_next != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_araddr    <= '0;
      r_beat_addr <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_req_hs) begin
        r_araddr    <= {req_addr[WIDTH-1:2], 2'b00};
        r_beat_addr <= {req_addr[WIDTH-1:2], 2'b00};
      end else if (w_push) begin
        r_beat_addr <= r_beat_addr + WIDTH'(4);
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem_data[gi] <= '0;
          r_mem_addr[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_mem_data[gi] <= rdata;
          r_mem_addr[gi] <= r_beat_addr;
        end
      end
    end
  endgenerate

`ifdef FETCH_ERR_CHECK_EN
  logic [8:0] r_beat_cnt;
  logic       r_err;
  logic       w_unused_bits;

  assign w_unused_bits = ^req_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_ar_hs) begin
      r_beat_cnt <= '0;
    end else if (w_beat_acc) begin
      r_beat_cnt <= r_beat_cnt + 9'd1;
      // rlast must coincide exactly with the final beat of the burst
      if (rresp || (rlast != (r_beat_cnt == {1'b0, arlen}))) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{req_addr[1:0], rresp, w_ar_hs};
  assign err = 1'b0;
`endif

  assign req_ready   = w_req_ready;
  assign rready      = w_rready;
  assign instr_valid = (r_count != '0);
  assign instr_data  = r_mem_data[r_rd_ptr];
  assign instr_addr  = r_mem_addr[r_rd_ptr];
  assign arvalid     = r_arvalid;
  assign araddr      = r_araddr;
  assign arburst     = 2'b01;
  assign arsize      = 3'b010;
  assign arlen       = 8'(BURST_LEN - 1);
  assign busy        = r_busy;
endmodule

// File: tb/tb_instr_fetch_axi_master.sv
// Randomized bench for instr_fetch_axi_master: an AR/R responder, a consumer and a
// beat-level reference model (occupancy, expected beat list, sticky error flag).
module tb_instr_fetch_axi_master;
  localparam int BL    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_data, instr_addr;
  logic        instr_ready = 1'b0;
  logic        arvalid;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic        rresp = 1'b0;
  logic        rready, busy, err;

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;

  instr_fetch_axi_master #(.WIDTH(32), .BURST_LEN(BL), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_addr(instr_addr), .instr_ready(instr_ready),
    .arvalid(arvalid), .araddr(araddr), .arburst(arburst), .arsize(arsize),
    .arlen(arlen), .arready(arready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
    .rresp(rresp), .rready(rready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; flush = 0; instr_ready = 0; arready = 0;
    rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    err_exp = 0;
    #1;
    chk1("rst_arvalid", arvalid, 0);
    chk32("rst_araddr", araddr, 32'h0);
    chk1("rst_rready", rready, 0);
    chk1("rst_instr_valid", instr_valid, 0);
    chk32("rst_instr_data", instr_data, 32'h0);
    chk32("rst_instr_addr", instr_addr, 32'h0);
    chk1("rst_busy", busy, 0);
    chk1("rst_err", err, 0);
    chk1("rst_req_ready", req_ready, 1);
    nxt();
    nxt();
    rst_n = 1;
    nxt();
    $display("reset done");
  endtask

  // One full burst: responder with AR wait, random R gaps, consumer with stall/random ready.
  task automatic run_burst(input logic [31:0] addr, input int ar_wait, input int rv_pct,
                           input int ir_pct, input int stall, input int rresp_beat,
                           input int rlast_beat);
    logic [31:0] base;
    logic [31:0] bd [BL];
    int nb, acc, cons, occ, waited, cyc;
    bit ar_done, ar_hs, r_hs, pop, exp_rr;
    base = {addr[31:2], 2'b00};
    nb = rlast_beat + 1;
    acc = 0; cons = 0; occ = 0; waited = 0; cyc = 0; ar_done = 0;
    for (int i = 0; i < BL; i++) bd[i] = $urandom;
    req_valid = 1; req_addr = addr;
    #1;
    chk1("req_ready", req_ready, 1);
    nxt();
    req_valid = 0; req_addr = $urandom;
    while (!(cons == nb && acc == nb) && cyc < 300) begin
      arready = !ar_done && (waited >= ar_wait);
      rvalid = ar_done && (acc < nb) && ($urandom_range(99) < rv_pct);
      rdata = rvalid ? bd[acc] : $urandom;
      rlast = rvalid && (acc == rlast_beat);
      rresp = rvalid && (acc == rresp_beat);
      instr_ready = (cyc >= stall) && ($urandom_range(99) < ir_pct);
      #1;
      exp_rr = ar_done && (acc < nb) && (occ < DEPTH);
      chk1("arvalid", arvalid, !ar_done);
      if (!ar_done) begin
        chk32("araddr", araddr, base);
        chk32("arlen", 32'(arlen), 32'(BL - 1));
        chk32("arburst", 32'(arburst), 32'h1);
        chk32("arsize", 32'(arsize), 32'h2);
      end
      chk1("rready", rready, exp_rr);
      chk1("busy", busy, !(ar_done && acc == nb));
      chk1("instr_valid", instr_valid, occ > 0);
      if (occ > 0) begin
        chk32("instr_data", instr_data, bd[cons]);
        chk32("instr_addr", instr_addr, base + 32'(4 * cons));
      end
      chk1("err", err, err_exp);
      ar_hs = !ar_done && arready;
      r_hs = rvalid && exp_rr;
      pop = (occ > 0) && instr_ready;
`ifdef FETCH_ERR_CHECK_EN
      if (r_hs && (rresp || (rlast != (acc == BL - 1)))) err_exp = 1;
`endif
      nxt();
      if (ar_hs) ar_done = 1; else if (!ar_done) waited++;
      if (r_hs) begin acc++; occ++; end
      if (pop) begin cons++; occ--; end
      cyc++;
    end
    idle_inputs();
    chk1("burst_in_budget", cyc < 300, 1);
    chk1("busy_after", busy, 0);
    chk1("instr_valid_after", instr_valid, 0);
    chk1("err_after", err, err_exp);
    $display("burst addr=%h beats=%0d cycles=%0d err=%b", addr, nb, cyc, err);
  endtask

  // Flush while beats are buffered: buffer clears, rest of burst drained.
  task automatic flush_in_data();
    req_valid = 1; req_addr = 32'h200; nxt();
    req_valid = 0; arready = 1; nxt();
    arready = 0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1; rdata = 32'hB0 + 32'(i); rlast = 0;
      #1; chk1("fd_rready_fill", rready, 1);
      nxt();
    end
    rvalid = 0; flush = 1;
    #1; chk1("fd_valid_before", instr_valid, 1);
    nxt();
    flush = 0;
    for (int i = 2; i < BL; i++) begin
      rvalid = 1; rdata = 32'hB0 + 32'(i); rlast = (i == BL - 1);
      #1;
      chk1("fd_valid_drain", instr_valid, 0);
      chk1("fd_rready_drain", rready, 1);
      chk1("fd_busy", busy, 1);
      nxt();
    end
    idle_inputs();
    #1;
    chk1("fd_busy_end", busy, 0);
    chk1("fd_req_ready", req_ready, 1);
    chk1("fd_valid_end", instr_valid, 0);
    nxt();
    $display("flush in DATA done");
  endtask

  // Flush while AR is pending: AR stays up, then all beats drained.
  task automatic flush_in_addr();
    req_valid = 1; req_addr = 32'h300; nxt();
    req_valid = 0; flush = 1;
    #1; chk1("fa_arvalid_flush", arvalid, 1);
    nxt();
    flush = 0;
    #1; chk1("fa_arvalid_held", arvalid, 1);
    chk32("fa_araddr_held", araddr, 32'h300);
    nxt();
    arready = 1; nxt();
    arready = 0;
    for (int i = 0; i < BL; i++) begin
      rvalid = 1; rdata = $urandom; rlast = (i == BL - 1);
      #1;
      chk1("fa_arvalid_gone", arvalid, 0);
      chk1("fa_rready", rready, 1);
      chk1("fa_valid", instr_valid, 0);
      nxt();
    end
    idle_inputs();
    #1;
    chk1("fa_busy_end", busy, 0);
    chk1("fa_valid_end", instr_valid, 0);
    nxt();
    $display("flush in ADDR done");
  endtask

  task automatic flush_in_idle();
    flush = 1; req_valid = 1; req_addr = 32'h400;
    #1; chk1("fi_req_ready", req_ready, 0);
    nxt();
    idle_inputs();
    #1;
    chk1("fi_arvalid", arvalid, 0);
    chk1("fi_busy", busy, 0);
    nxt();
    $display("flush in IDLE done");
  endtask

  task automatic reset_mid_burst();
    req_valid = 1; req_addr = 32'h500; nxt();
    req_valid = 0; arready = 1; nxt();
    arready = 0; rvalid = 1; rdata = 32'h55; nxt();
    rvalid = 0;
    rst_n = 0;
    #1;
    chk1("rm_busy", busy, 0);
    chk1("rm_arvalid", arvalid, 0);
    chk1("rm_valid", instr_valid, 0);
    chk1("rm_rready", rready, 0);
    do_reset();
    $display("reset mid-burst done");
  endtask

  initial begin
    idle_inputs();
    do_reset();
    // basic burst, consumer always ready
    run_burst(32'h100, 0, 100, 100, 0, -1, BL - 1);
    // AR backpressure: arready low for 5 cycles
    run_burst(32'h1000, 5, 100, 100, 0, -1, BL - 1);
    // consumer stall until buffer full
    run_burst(32'h2000, 0, 100, 100, 8, -1, BL - 1);
    // misaligned address with wrap
    run_burst(32'hFFFF_FFFE, 1, 100, 100, 0, -1, BL - 1);
    flush_in_data();
    flush_in_addr();
    flush_in_idle();
    reset_mid_burst();
    for (int n = 0; n < 8; n++)
      run_burst($urandom, $urandom_range(0, 3), $urandom_range(40, 100),
                $urandom_range(30, 100), $urandom_range(0, 4), -1, BL - 1);
    // error response on beat 2, sticky until reset
    run_burst(32'h700, 0, 100, 100, 0, 2, BL - 1);
    for (int i = 0; i < 3; i++) begin
      #1; chk1("err_sticky", err, err_exp);
      nxt();
    end
    do_reset();
    // early rlast on beat 1
    run_burst(32'h800, 0, 100, 100, 0, -1, 1);
    run_burst(32'h900, 0, 100, 100, 0, -1, BL - 1);
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
